// File: rtl/btn_step_pulser.sv
// Debounces a bouncy push-button and emits one-cycle step pulses, with auto-repeat while the button is held.
// Latency: 2-cycle synchronizer + DEBOUNCE_CYCLES from the first stable-high sample to the first StepPulse.
// Backpressure: none; this is a free-running strobe source with no ready input.
module btn_step_pulser #(
    parameter int DEBOUNCE_CYCLES = 8192,
    parameter int REPEAT_DELAY    = 4000000,
    parameter int REPEAT_PERIOD   = 1000000,
    parameter int CNT_W           = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_btn,
    output logic             o_btn_level,
    output logic             o_step_pulse,
    output logic             o_repeat_active,
    output logic [CNT_W-1:0] o_step_count
);

    // A single timer serves every state, so it is sized for the longest interval.
    localparam int MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_T = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
    localparam int TMR_W = $clog2(MAX_T + 1);

    localparam logic [TMR_W-1:0] DB_LAST  = TMR_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] RD_LAST  = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] RP_LAST  = TMR_W'(REPEAT_PERIOD - 1);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_DB_PRESS   = 3'd1,
        ST_HELD       = 3'd2,
        ST_REPEAT     = 3'd3,
        ST_DB_RELEASE = 3'd4
    } state_t;

    logic             r_sync1;
    logic             r_sync2;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [TMR_W-1:0] r_timer;
    logic [TMR_W-1:0] w_timer_nxt;
    logic             w_timer_clr;
    logic             w_pulse;
    logic             w_level_nxt;
    logic             w_repeat_nxt;
    logic             r_btn_level;
    logic             r_step_pulse;
    logic             r_repeat_active;
    logic [CNT_W-1:0] r_step_count;

    // Two-flop synchronizer for the asynchronous button pin.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Next-state logic; the pulse is raised only on the press-accept and repeat transitions.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_clr = 1'b0;
        w_pulse     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_sync2) w_state_nxt = ST_DB_PRESS;
            end
            ST_DB_PRESS: begin
                if (!r_sync2) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_timer == DB_LAST) begin
                    w_state_nxt = ST_HELD;
                    w_pulse     = 1'b1;
                end
            end
            ST_HELD: begin
                if (!r_sync2) begin
                    w_state_nxt = ST_DB_RELEASE;
                end else if (r_timer == RD_LAST) begin
                    w_state_nxt = ST_REPEAT;
                    w_pulse     = 1'b1;
                end
            end
            ST_REPEAT: begin
                if (!r_sync2) begin
                    w_state_nxt = ST_DB_RELEASE;
                end else if (r_timer == RP_LAST) begin
                    w_timer_clr = 1'b1;
                    w_pulse     = 1'b1;
                end
            end
            ST_DB_RELEASE: begin
                // Re-press during release debounce goes back to HELD without a new pulse.
                if (r_sync2) begin
                    w_state_nxt = ST_HELD;
                end else if (r_timer == DB_LAST) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Timer restarts on every state change and on each repeat period; idles at zero.
    always_comb begin
        w_timer_nxt = r_timer + 1'b1;
        if (w_state_nxt != r_state || w_timer_clr || r_state == ST_IDLE) begin
            w_timer_nxt = '0;
        end
    end

    // Level is high from accepted press to accepted release; repeat flag only in REPEAT.
    always_comb begin
        w_level_nxt  = (w_state_nxt == ST_HELD) || (w_state_nxt == ST_REPEAT) ||
                       (w_state_nxt == ST_DB_RELEASE);
        w_repeat_nxt = (w_state_nxt == ST_REPEAT);
    end

    // State, timer and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= ST_IDLE;
            r_timer         <= '0;
            r_btn_level     <= 1'b0;
            r_step_pulse    <= 1'b0;
            r_repeat_active <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_timer         <= w_timer_nxt;
            r_btn_level     <= w_level_nxt;
            r_step_pulse    <= w_pulse;
            r_repeat_active <= w_repeat_nxt;
        end
    end

    // Step counter advances during the pulse cycle; wraps silently.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_step_count <= '0;
        end else if (r_step_pulse) begin
            r_step_count <= r_step_count + 1'b1;
        end
    end

    assign o_btn_level     = r_btn_level;
    assign o_step_pulse    = r_step_pulse;
    assign o_repeat_active = r_repeat_active;
    assign o_step_count    = r_step_count;

endmodule

// File: tb/tb_btn_step_pulser.sv
// Directed bench for btn_step_pulser with short debounce/repeat intervals.
// Latency under test: press-to-pulse of 6 cycles, repeat at +26 then every 8.
// Backpressure: none.
module tb_btn_step_pulser;

    logic       clk;
    logic       rst_n;
    logic       btn;
    logic       btn_level;
    logic       step_pulse;
    logic       repeat_active;
    logic [3:0] step_count;

    int n_checks = 0;
    int n_errors = 0;

    int q_pulse[$];
    int rep_rise;
    int rep_fall;
    int lvl_rise;
    int lvl_fall;
    int impl_err;
    int dbl_pulse;

    btn_step_pulser #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8),
        .CNT_W          (4)
    ) u_dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_btn          (btn),
        .o_btn_level    (btn_level),
        .o_step_pulse   (step_pulse),
        .o_repeat_active(repeat_active),
        .o_step_count   (step_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Press at the next edge (k=0 is the first edge sampling 1), release so that edge
    // 'hold' is the first to sample 0, and log events by edge index for 'total' edges.
    task automatic watch(input int hold, input int total);
        logic prev_rep;
        logic prev_lvl;
        logic prev_pulse;
        q_pulse.delete();
        rep_rise  = -1;
        rep_fall  = -1;
        lvl_rise  = -1;
        lvl_fall  = -1;
        impl_err  = 0;
        dbl_pulse = 0;
        prev_rep   = repeat_active;
        prev_lvl   = btn_level;
        prev_pulse = step_pulse;
        btn = 1'b1;
        for (int k = 0; k < total; k++) begin
            @(posedge clk);
            #1;
            if (step_pulse) q_pulse.push_back(k);
            if (step_pulse && prev_pulse) dbl_pulse++;
            if (repeat_active && !prev_rep && rep_rise < 0) rep_rise = k;
            if (!repeat_active && prev_rep && rep_fall < 0) rep_fall = k;
            if (btn_level && !prev_lvl && lvl_rise < 0) lvl_rise = k;
            if (!btn_level && prev_lvl && lvl_fall < 0) lvl_fall = k;
            if (repeat_active && !btn_level) impl_err++;
            prev_rep   = repeat_active;
            prev_lvl   = btn_level;
            prev_pulse = step_pulse;
            if (k == hold - 1) btn = 1'b0;
        end
    endtask

    function automatic int qget(input int idx);
        if (idx < q_pulse.size()) return q_pulse[idx];
        return -1;
    endfunction

    initial begin : stim
        int exp_rep[6];
        logic [3:0] pat;
        int lvl_seen;
        int npulse;
        exp_rep = '{6, 26, 34, 42, 50, 58};

        // Test 1: reset held with button pressed.
        rst_n = 1'b0;
        btn   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_level", {31'd0, btn_level}, 0);
        check("rst_pulse", {31'd0, step_pulse}, 0);
        check("rst_repeat", {31'd0, repeat_active}, 0);
        check("rst_count", {28'd0, step_count}, 0);
        rst_n = 1'b1;
        watch(10, 24);
        check("t1_npulse", q_pulse.size(), 1);
        check("t1_pulse_pos", qget(0), 6);
        check("t1_count", {28'd0, step_count}, 1);

        // Test 2: clean press of 10 cycles.
        watch(10, 24);
        check("t2_npulse", q_pulse.size(), 1);
        check("t2_pulse_pos", qget(0), 6);
        check("t2_level_rise", lvl_rise, 6);
        check("t2_level_fall", lvl_fall, 16);
        check("t2_count", {28'd0, step_count}, 2);

        // Test 3: bounce 1,0,1,0 two cycles each, then low.
        pat = 4'b0101;
        lvl_seen = 0;
        npulse   = 0;
        for (int k = 0; k < 28; k++) begin
            btn = (k < 8) ? pat[k/2] : 1'b0;
            @(posedge clk);
            #1;
            if (step_pulse) npulse++;
            if (btn_level) lvl_seen++;
        end
        check("t3_npulse", npulse, 0);
        check("t3_level", lvl_seen, 0);
        check("t3_count", {28'd0, step_count}, 2);

        // Test 4: held 60 cycles -> delay then periodic repeat.
        watch(60, 80);
        check("t4_npulse", q_pulse.size(), 6);
        for (int i = 0; i < 6; i++) check($sformatf("t4_pulse%0d", i), qget(i), exp_rep[i]);
        check("t4_rep_rise", rep_rise, 26);
        check("t4_rep_fall", rep_fall, 62);
        check("t4_rep_implies_level", impl_err, 0);
        check("t4_no_double", dbl_pulse, 0);
        check("t4_count", {28'd0, step_count}, 8);

        // Test 5: 17 presses from a fresh reset -> counter wraps to 1.
        rst_n = 1'b0;
        #1;
        check("t5_rst_count", {28'd0, step_count}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int p = 0; p < 16; p++) watch(8, 16);
        check("t5_count16", {28'd0, step_count}, 0);
        watch(8, 16);
        check("t5_count17", {28'd0, step_count}, 1);

        // Test 6: reset mid-repeat with button held.
        watch(1000, 30);
        check("t6_in_repeat", {31'd0, repeat_active}, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_level", {31'd0, btn_level}, 0);
        check("t6_rst_repeat", {31'd0, repeat_active}, 0);
        check("t6_rst_pulse", {31'd0, step_pulse}, 0);
        check("t6_rst_count", {28'd0, step_count}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        watch(1000, 10);
        check("t6_npulse", q_pulse.size(), 1);
        check("t6_pulse_pos", qget(0), 6);
        check("t6_count", {28'd0, step_count}, 1);
        btn = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("t6_level_off", {31'd0, btn_level}, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
